// File: rtl/otp_pkg.sv
// Shared defaults and the FSM state encoding for the one-time-pad scheduler.
package otp_pkg;

    localparam int SLOTS = 8;
    localparam int DW    = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } otp_state_e;

endpackage

// File: rtl/otp_rr_arb2.sv
// Two-requester round-robin arbiter: requester 0 is encrypt, requester 1 is decrypt.
module otp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // prio == 0 favours requester 0 when both request.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && (!req[1] || !prio)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

    // After any grant the other requester becomes favoured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/otp_pad_scheduler.sv
// One-time-pad scheduler: encrypts into fresh pad slots, decrypts and burns used slots.
module otp_pad_scheduler #(
    parameter int SLOTS = otp_pkg::SLOTS,
    parameter int DW    = otp_pkg::DW,
    parameter int IDX_W = otp_pkg::IDX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enc_valid,
    input  logic [DW-1:0]    enc_data,
    output logic             enc_ready,
    input  logic             dec_valid,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [DW-1:0]    dec_data,
    output logic             dec_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DW-1:0]    rsp_data,
    output logic [IDX_W-1:0] rsp_idx,
    output logic             rsp_is_dec,
    output logic             rsp_err,
    input  logic [DW-1:0]    prn,
    output logic             prn_adv,
    output logic             pad_we,
    output logic [IDX_W-1:0] pad_wa,
    output logic [DW-1:0]    pad_wd,
    output logic [IDX_W-1:0] pad_ra,
    input  logic [DW-1:0]    pad_rd,
    output logic [IDX_W:0]   free_cnt,
    output logic [1:0]       state_dbg
);

    import otp_pkg::*;

    otp_state_e       state;
    logic [SLOTS-1:0] used;
    logic [DW-1:0]    data_q;
    logic             is_dec_q;
    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             in_idle;
    logic             accept;
    logic [IDX_W-1:0] free_slot;
    logic [IDX_W:0]   free_sum;

    // Lowest-numbered free slot and the free-slot count, both derived only from used.
    always_comb begin
        free_slot = '0;
        free_sum  = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!used[i]) begin
                free_slot = IDX_W'(i);
            end
        end
        for (int i = 0; i < SLOTS; i++) begin
            free_sum = free_sum + {{IDX_W{1'b0}}, ~used[i]};
        end
    end

    assign free_cnt  = free_sum;
    assign state_dbg = state;

    // Handshakes: a request transfers on the cycle where valid && ready are both high;
    // ready is only offered in IDLE to the arbiter winner. The response transfers on
    // rsp_valid && rsp_ready, with all rsp_* fields held stable until then.
    assign req[0]    = enc_valid && (free_sum != '0);
    assign req[1]    = dec_valid;
    assign in_idle   = (state == ST_IDLE);
    assign enc_ready = in_idle && gnt[0];
    assign dec_ready = in_idle && gnt[1];
    assign accept    = in_idle && (gnt != 2'b00);

    otp_rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .advance (accept),
        .gnt     (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            used       <= '0;
            data_q     <= '0;
            is_dec_q   <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_idx    <= '0;
            rsp_is_dec <= 1'b0;
            rsp_err    <= 1'b0;
            pad_we     <= 1'b0;
            prn_adv    <= 1'b0;
            pad_wa     <= '0;
            pad_wd     <= '0;
            pad_ra     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state    <= ST_EXEC;
                        is_dec_q <= gnt[1];
                        if (gnt[1]) begin
                            data_q <= dec_data;
                            pad_ra <= dec_idx;
                        end else begin
                            // prn only moves on prn_adv, so capturing it now equals its EXEC value.
                            data_q  <= enc_data;
                            pad_we  <= 1'b1;
                            prn_adv <= 1'b1;
                            pad_wa  <= free_slot;
                            pad_wd  <= prn;
                        end
                    end
                end
                ST_EXEC: begin
                    state      <= ST_RESP;
                    pad_we     <= 1'b0;
                    prn_adv    <= 1'b0;
                    rsp_valid  <= 1'b1;
                    rsp_is_dec <= is_dec_q;
                    if (!is_dec_q) begin
                        used[pad_wa] <= 1'b1;
                        rsp_data     <= data_q ^ pad_wd;
                        rsp_idx      <= pad_wa;
                        rsp_err      <= 1'b0;
                    end else begin
                        rsp_idx <= pad_ra;
                        if (used[pad_ra]) begin
                            used[pad_ra] <= 1'b0;
                            rsp_data     <= data_q ^ pad_rd;
                            rsp_err      <= 1'b0;
                        end else begin
                            rsp_data <= '0;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Self-checking bench for otp_pad_scheduler with an external pad file and prn source.
module tb_otp_pad_scheduler;

    logic       clk;
    logic       rst_n;
    logic       enc_valid, enc_ready, dec_valid, dec_ready;
    logic [7:0] enc_data, dec_data;
    logic [2:0] dec_idx;
    logic       rsp_valid, rsp_ready, rsp_is_dec, rsp_err;
    logic [7:0] rsp_data;
    logic [2:0] rsp_idx;
    logic [7:0] prn;
    logic       prn_adv, pad_we;
    logic [2:0] pad_wa, pad_ra;
    logic [7:0] pad_wd, pad_rd;
    logic [3:0] free_cnt;
    logic [1:0] state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: which slots hold a live pad, what pad, next prn, round-robin favour.
    bit         m_used [8];
    logic [7:0] m_pad  [8];
    logic [7:0] m_prn;
    bit         m_favor_dec;

    logic [7:0] pad_mem [8] = '{default: 8'h00};

    otp_pad_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_valid  (enc_valid),
        .enc_data   (enc_data),
        .enc_ready  (enc_ready),
        .dec_valid  (dec_valid),
        .dec_idx    (dec_idx),
        .dec_data   (dec_data),
        .dec_ready  (dec_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_idx    (rsp_idx),
        .rsp_is_dec (rsp_is_dec),
        .rsp_err    (rsp_err),
        .prn        (prn),
        .prn_adv    (prn_adv),
        .pad_we     (pad_we),
        .pad_wa     (pad_wa),
        .pad_wd     (pad_wd),
        .pad_ra     (pad_ra),
        .pad_rd     (pad_rd),
        .free_cnt   (free_cnt),
        .state_dbg  (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] next_prn(input logic [7:0] x);
        return x * 8'd5 + 8'd1;
    endfunction

    initial prn = 8'h3C;
    always @(posedge clk) if (prn_adv) prn <= next_prn(prn);
    always @(posedge clk) if (pad_we) pad_mem[pad_wa] <= pad_wd;
    assign pad_rd = pad_mem[pad_ra];

    function automatic int m_free_count();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!m_used[i]) n++;
        return n;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < 8; i++) if (!m_used[i]) return i;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_used[i] = 0;
        m_favor_dec = 0;
    endtask

    // Called just after a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic run_txn(input logic ev, input logic [7:0] ed, input logic dv,
                           input logic [2:0] di, input logic [7:0] dd,
                           input int hold, input logic keep);
        logic       enc_ok, win_dec, exp_err;
        int         slot;
        logic [7:0] exp_data, exp_wd;
        logic [2:0] exp_idx;
        enc_valid = ev; enc_data = ed; dec_valid = dv; dec_idx = di; dec_data = dd;
        rsp_ready = 1'b0;
        #1;
        enc_ok  = ev && (m_free_count() > 0);
        win_dec = dv && (!enc_ok || m_favor_dec);
        check("enc_ready", enc_ready, enc_ok && !win_dec);
        check("dec_ready", dec_ready, win_dec);
        m_favor_dec = !win_dec;
        exp_wd = m_prn;
        slot   = 0;
        if (!win_dec) begin
            slot          = m_lowest_free();
            exp_data      = ed ^ m_prn;
            exp_idx       = slot[2:0];
            exp_err       = 1'b0;
            m_pad[slot]   = m_prn;
            m_used[slot]  = 1;
            m_prn         = next_prn(m_prn);
        end else begin
            exp_idx = di;
            if (m_used[di]) begin
                exp_data   = dd ^ m_pad[di];
                exp_err    = 1'b0;
                m_used[di] = 0;
            end else begin
                exp_data = 8'h00;
                exp_err  = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (!keep) begin enc_valid = 1'b0; dec_valid = 1'b0; end
        check("exec_rsp_valid", rsp_valid, 0);
        check("exec_pad_we", pad_we, !win_dec);
        check("exec_prn_adv", prn_adv, !win_dec);
        check("exec_readies", {enc_ready, dec_ready}, 0);
        if (!win_dec) begin
            check("exec_pad_wa", pad_wa, slot);
            check("exec_pad_wd", pad_wd, exp_wd);
        end else begin
            check("exec_pad_ra", pad_ra, di);
        end
        @(negedge clk);
        for (int c = 0; c <= hold; c++) begin
            check("rsp_valid", rsp_valid, 1);
            check("rsp_data", rsp_data, exp_data);
            check("rsp_idx", rsp_idx, exp_idx);
            check("rsp_is_dec", rsp_is_dec, win_dec);
            check("rsp_err", rsp_err, exp_err);
            check("resp_pad_we", {pad_we, prn_adv}, 0);
            check("resp_readies", {enc_ready, dec_ready}, 0);
            if (c < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("idle_rsp_valid", rsp_valid, 0);
        check("free_cnt", free_cnt, m_free_count());
    endtask

    initial begin
        int pick;
        logic ev, dv;
        logic [2:0] di;
        rst_n = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; rsp_ready = 1'b0;
        enc_data = 8'h00; dec_data = 8'h00; dec_idx = 3'd0;
        m_prn = 8'h3C;
        m_reset();
        repeat (3) @(negedge clk);
        check("rst_free_cnt", free_cnt, 8);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_outputs", {pad_we, prn_adv, enc_ready, dec_ready, rsp_err, rsp_is_dec}, 0);
        check("rst_rsp_data", rsp_data, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single encrypt 0x5A with prn 0x3C, then decrypt it back and retry the burnt slot.
        run_txn(1, 8'h5A, 0, 3'd0, 8'h00, 0, 0);
        run_txn(0, 8'h00, 1, 3'd0, 8'h66, 0, 0);
        run_txn(0, 8'h00, 1, 3'd0, 8'h66, 0, 0);

        // Response backpressure for 5 cycles.
        run_txn(1, 8'hC3, 0, 3'd0, 8'h00, 5, 0);

        // Fill all slots, then show encrypt is held off while full.
        for (int i = 0; i < 7; i++) run_txn(1, 8'($urandom), 0, 3'd0, 8'h00, 0, 0);
        enc_valid = 1'b1;
        enc_data  = 8'h11;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_enc_ready", enc_ready, 0);
            check("full_rsp_valid", rsp_valid, 0);
            @(negedge clk);
        end
        run_txn(1, 8'h11, 1, 3'd3, 8'($urandom), 0, 0);
        run_txn(1, 8'h22, 0, 3'd0, 8'h00, 0, 0);

        // Both channels held valid: grants alternate.
        for (int i = 0; i < 6; i++) run_txn(1, 8'($urandom), 1, 3'($urandom_range(0, 7)), 8'($urandom), 0, (i < 5));

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            ev = 1'($urandom_range(0, 1));
            dv = 1'($urandom_range(0, 1));
            if (!ev && !dv) ev = 1'b1;
            if (m_free_count() == 0) dv = 1'b1;
            di = 3'($urandom_range(0, 7));
            pick = $urandom_range(0, 9);
            if (pick < 7) for (int s = 0; s < 8; s++) if (m_used[(int'(di) + s) % 8]) begin
                di = 3'((int'(di) + s) % 8);
                break;
            end
            run_txn(ev, 8'($urandom), dv, di, 8'($urandom), $urandom_range(0, 2), 0);
        end

        // Reset pulse in the middle of an encrypt EXEC.
        enc_valid = 1'b1;
        enc_data  = 8'h77;
        @(posedge clk);
        @(negedge clk);
        enc_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", rsp_valid, 0);
        check("abort_pad_we", {pad_we, prn_adv}, 0);
        check("abort_free_cnt", free_cnt, 8);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_abort_rsp_valid", rsp_valid, 0);
            check("post_abort_free_cnt", free_cnt, 8);
        end
        run_txn(1, 8'h5A, 1, 3'd2, 8'h00, 0, 0);
        run_txn(0, 8'h00, 1, 3'd0, 8'($urandom), 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
